coo_dense_encoder: RTL



---
 rtl/coo_dense_encoder.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/coo_dense_encoder.sv
// Dense row-major matrix to COO stream encoder.
// Buffers nonzeros, then emits a header {ROWS, COLS, nnz} and the entries.
module coo_dense_encoder #(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int DATA_W  = 32,
    parameter int IDX_W   = 8,
    parameter int MAX_NNZ = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_row,
    output logic [IDX_W-1:0]  out_col,
    output logic [DATA_W-1:0] out_val,
    output logic              out_hdr,
    output logic              out_last,
    output logic              overflow
);

    localparam int CNT_W = $clog2(MAX_NNZ + 1);
    localparam int AW    = (MAX_NNZ > 1) ? $clog2(MAX_NNZ) : 1;

    localparam logic [IDX_W-1:0] ROW_MAX = IDX_W'(ROWS - 1);
    localparam logic [IDX_W-1:0] COL_MAX = IDX_W'(COLS - 1);
    localparam logic [IDX_W-1:0] HDR_ROW = IDX_W'(ROWS);
    localparam logic [IDX_W-1:0] HDR_COL = IDX_W'(COLS);
    localparam logic [CNT_W-1:0] NNZ_MAX = CNT_W'(MAX_NNZ);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        EMIT_HDR = 2'd1,
        EMIT_ENT = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [IDX_W-1:0] row_cnt;
    logic [IDX_W-1:0] col_cnt;
    logic [CNT_W-1:0] nnz;
    logic [CNT_W-1:0] nnz_nxt;
    logic [CNT_W-1:0] rd_ptr;
    logic [CNT_W-1:0] rd_ptr_inc;
    logic [CNT_W-1:0] last_ptr;
    logic [AW-1:0]    rd_idx;

    logic [IDX_W-1:0]  buf_row [MAX_NNZ];
    logic [IDX_W-1:0]  buf_col [MAX_NNZ];
    logic [DATA_W-1:0] buf_val [MAX_NNZ];

    logic in_fire;
    logic out_fire;
    logic elem_nz;
    logic at_end;
    logic store;
    logic drop;
    logic frame_done;

    logic              ov_nxt;
    logic              hdr_nxt;
    logic              last_nxt;
    logic [IDX_W-1:0]  row_nxt;
    logic [IDX_W-1:0]  col_nxt;
    logic [DATA_W-1:0] val_nxt;

    assign in_ready   = rst_n & (state == COLLECT);
    assign in_fire    = in_valid & in_ready;
    assign out_fire   = out_valid & out_ready;
    assign elem_nz    = (in_data != '0);
    assign at_end     = (row_cnt == ROW_MAX) && (col_cnt == COL_MAX);
    assign store      = in_fire & elem_nz & (nnz != NNZ_MAX);
    assign drop       = in_fire & elem_nz & (nnz == NNZ_MAX);
    assign frame_done = out_fire & out_last;

    assign nnz_nxt    = store ? nnz + ONE : nnz;
    assign rd_ptr_inc = rd_ptr + ONE;
    assign last_ptr   = nnz - ONE;

    // Prefetch address of the entry that follows the word on the bus.
    assign rd_idx = (state == EMIT_ENT) ? AW'(rd_ptr_inc) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            COLLECT: begin
                if (in_fire && at_end) begin
                    state_nxt = EMIT_HDR;
                end
            end
            EMIT_HDR: begin
                if (out_fire) begin
                    state_nxt = (nnz == '0) ? COLLECT : EMIT_ENT;
                end
            end
            EMIT_ENT: begin
                if (frame_done) begin
                    state_nxt = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    // Next value of the registered output word; holds unless a handshake
    // or the end of collection loads a new one.
    always_comb begin
        ov_nxt   = out_valid;
        hdr_nxt  = out_hdr;
        last_nxt = out_last;
        row_nxt  = out_row;
        col_nxt  = out_col;
        val_nxt  = out_val;
        unique case (state)
            COLLECT: begin
                if (in_fire && at_end) begin
                    ov_nxt   = 1'b1;
                    hdr_nxt  = 1'b1;
                    last_nxt = (nnz_nxt == '0);
                    row_nxt  = HDR_ROW;
                    col_nxt  = HDR_COL;
                    val_nxt  = DATA_W'(nnz_nxt);
                end
            end
            EMIT_HDR, EMIT_ENT: begin
                if (out_fire && out_last) begin
                    ov_nxt   = 1'b0;
                    hdr_nxt  = 1'b0;
                    last_nxt = 1'b0;
                    row_nxt  = '0;
                    col_nxt  = '0;
                    val_nxt  = '0;
                end else if (out_fire) begin
                    ov_nxt   = 1'b1;
                    hdr_nxt  = 1'b0;
                    row_nxt  = buf_row[rd_idx];
                    col_nxt  = buf_col[rd_idx];
                    val_nxt  = buf_val[rd_idx];
                    if (state == EMIT_HDR) begin
                        last_nxt = (nnz == ONE);
                    end else begin
                        last_nxt = (rd_ptr_inc == last_ptr);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_hdr   <= 1'b0;
            out_last  <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
            out_val   <= '0;
        end else begin
            out_valid <= ov_nxt;
            out_hdr   <= hdr_nxt;
            out_last  <= last_nxt;
            out_row   <= row_nxt;
            out_col   <= col_nxt;
            out_val   <= val_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_cnt  <= '0;
            col_cnt  <= '0;
            nnz      <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else if (frame_done) begin
            row_cnt  <= '0;
            col_cnt  <= '0;
            nnz      <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (in_fire) begin
                if (col_cnt == COL_MAX) begin
                    col_cnt <= '0;
                    row_cnt <= (row_cnt == ROW_MAX) ? '0 : row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end
            if (store) begin
                nnz <= nnz_nxt;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (out_fire && state == EMIT_ENT) begin
                rd_ptr <= rd_ptr_inc;
            end
        end
    end

    // Entry storage needs no reset; nnz bounds every read.
    always_ff @(posedge clk) begin
        if (store) begin
            buf_row[AW'(nnz)] <= row_cnt;
            buf_col[AW'(nnz)] <= col_cnt;
            buf_val[AW'(nnz)] <= in_data;
        end
    end

endmodule
